// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_loader
// Brief    : Byte-stream boot loader. It reads a word-count header and then
//            little-endian instruction words, and writes them to instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module instr_loader #(
    parameter int REG_WIDTH           = 32,
    parameter int INSTR_ADDR_WIDTH    = 32,
    parameter int NUM_OF_INSTRUCTIONS = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        wr_en,
    output logic [INSTR_ADDR_WIDTH-1:0] wr_addr,
    output logic [REG_WIDTH-1:0]        wr_data,
    output logic                        cpu_hold,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [7:0]                  words_loaded
);

    localparam int c_BYTES = REG_WIDTH / 8;
    localparam int c_BC_W  = (c_BYTES > 1) ? $clog2(c_BYTES) : 1;
    localparam logic [c_BC_W-1:0] c_LAST_BYTE = c_BC_W'(c_BYTES - 1);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_LEN  = 3'd1;
    localparam logic [2:0] c_LOAD = 3'd2;
    localparam logic [2:0] c_DONE = 3'd3;
    localparam logic [2:0] c_ERR  = 3'd4;

    logic [2:0]                  r_state;
    logic [c_BC_W-1:0]           r_byte_cnt;
    logic [7:0]                  r_words_left;
    logic [INSTR_ADDR_WIDTH-1:0] r_word_idx;
    logic [REG_WIDTH-9:0]        r_shift;
    logic                        r_wr_en;
    logic [INSTR_ADDR_WIDTH-1:0] r_wr_addr;
    logic [REG_WIDTH-1:0]        r_wr_data;
    logic                        r_done;
    logic                        r_cpu_hold;
    logic [7:0]                  r_words_loaded;

    logic                        w_busy;
    logic                        w_xfer;
    logic                        w_hdr_bad;
    logic [REG_WIDTH-1:0]        w_word;

    assign w_busy    = (r_state == c_LEN) || (r_state == c_LOAD);
    assign w_xfer    = in_valid && w_busy;
    assign w_hdr_bad = (in_data == 8'd0) ||
                       ({24'd0, in_data} > 32'(NUM_OF_INSTRUCTIONS));
    // Bytes enter at the top, so after a full word byte 0 sits in bits [7:0]
    assign w_word    = {in_data, r_shift};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_byte_cnt     <= '0;
            r_words_left   <= '0;
            r_word_idx     <= '0;
            r_shift        <= '0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_done         <= 1'b0;
            r_cpu_hold     <= 1'b1;
            r_words_loaded <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                c_IDLE, c_DONE, c_ERR: begin
                    if (start) begin
                        r_state        <= c_LEN;
                        r_done         <= 1'b0;
                        r_cpu_hold     <= 1'b1;
                        r_words_loaded <= '0;
                        r_byte_cnt     <= '0;
                        r_word_idx     <= '0;
                    end else if (r_state == c_DONE) begin
                        // The first DONE cycle carries the final write; release the core after it
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end
                end
                c_LEN: begin
                    if (w_xfer) begin
                        if (w_hdr_bad) begin
                            r_state <= c_ERR;
                        end else begin
                            r_words_left <= in_data;
                            r_state      <= c_LOAD;
                        end
                    end
                end
                c_LOAD: begin
                    if (w_xfer) begin
                        r_shift <= w_word[REG_WIDTH-1:8];
                        if (r_byte_cnt == c_LAST_BYTE) begin
                            r_byte_cnt     <= '0;
                            r_wr_en        <= 1'b1;
                            r_wr_addr      <= r_word_idx;
                            r_wr_data      <= w_word;
                            r_word_idx     <= r_word_idx + INSTR_ADDR_WIDTH'(1);
                            r_words_loaded <= r_words_loaded + 8'd1;
                            r_words_left   <= r_words_left - 8'd1;
                            if (r_words_left == 8'd1) begin
                                r_state <= c_DONE;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + c_BC_W'(1);
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready     = w_busy;
    assign busy         = w_busy;
    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign cpu_hold     = r_cpu_hold;
    assign done         = r_done;
    assign error        = (r_state == c_ERR);
    assign words_loaded = r_words_loaded;

endmodule
`default_nettype wire

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32: instruction word width.
REQ-002 SHALL have parameter INSTR_ADDR_WIDTH, default 32: width of the word-index write address.
REQ-003 SHALL have parameter NUM_OF_INSTRUCTIONS, default 128: instruction memory depth in words.
REQ-004 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port start  input  1: single-cycle request to begin a load.
REQ-007 SHALL have port in_data  input  8: incoming stream byte.
REQ-008 SHALL have port in_valid  input  1: in_data is valid.
REQ-009 SHALL have port in_ready  output  1: loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
REQ-010 SHALL have port wr_en  output  1: one-cycle instruction memory write strobe.
REQ-011 SHALL have port wr_addr  output  INSTR_ADDR_WIDTH: word index, not a byte address.
REQ-012 SHALL have port wr_data  output  REG_WIDTH: instruction word to write.
REQ-013 SHALL have port cpu_hold  output  1: holds the core in reset while the image is invalid.
REQ-014 SHALL have port busy  output  1: high in LEN and LOAD.
REQ-015 SHALL have port done  output  1: image fully written.
REQ-016 SHALL have port error  output  1: invalid length header.
REQ-017 SHALL have port words_loaded  output  8: count of wr_en pulses since the last accepted start.

Function
REQ-018 SHALL implement states IDLE, LEN, LOAD, DONE, ERR.
REQ-019 SHALL hold in_ready at 0 in IDLE, DONE and ERR, and at 1 in LEN and LOAD.
REQ-020 SHALL move to LEN on start in IDLE, DONE or ERR, clearing done, error, words_loaded and the byte/word counters, and asserting cpu_hold.
REQ-021 SHALL ignore start in LEN and LOAD.
REQ-022 SHALL not consume a byte in the cycle start is sampled, even if in_valid is high, because in_ready is still 0 that cycle.
REQ-023 SHALL, in LEN, capture the first accepted byte as the word count N.
REQ-024 SHALL go to ERR if N == 0 or N > NUM_OF_INSTRUCTIONS; otherwise it SHALL go to LOAD.
REQ-025 SHALL, in LOAD, assemble words little-endian: byte 0 of each word goes to bits [7:0] and byte 3 to bits [31:24].
REQ-026 SHALL, on acceptance of the 4th byte of word k, drive wr_en=1, wr_addr=k and wr_data equal to the assembled word in the next cycle only.
REQ-027 SHALL increment words_loaded in the same cycle that wr_en=1.
REQ-028 SHALL keep in_ready high during the wr_en cycle, so back-to-back bytes are accepted with no bubble.
REQ-029 SHALL enter DONE on acceptance of the last byte of word N-1; the final wr_en pulse then occurs in the first DONE cycle.
REQ-030 SHALL set done=1 and cpu_hold=0 one cycle after the final wr_en pulse, and hold them until start or rst.
REQ-031 SHALL, in ERR, drive error=1 and cpu_hold=1, issue no wr_en, and accept no bytes.
REQ-032 SHALL leave gaps in in_valid without effect: counters advance only on transfers.
REQ-033 SHALL never write a partial word.
REQ-034 SHALL hold wr_addr and wr_data stable when wr_en=0, at the last written values (0 after reset).

Reset
REQ-035 SHALL, on rst=1 at a clock edge, return to IDLE regardless of state, including mid-word and mid-load.
REQ-036 SHALL, after reset, drive cpu_hold=1, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, words_loaded=0.
REQ-037 SHALL give rst priority over start.
REQ-038 SHALL complete no pending write after reset.

Verification
REQ-039 Bench SHALL cover: start, then bytes 02, 78,56,34,12, EF,BE,AD,DE with continuous valid -> wr_en (0,0x12345678), then (1,0xDEADBEEF); done=1 and cpu_hold=0 one cycle after the 2nd write; words_loaded=2.
REQ-040 Bench SHALL cover: header 00, and separately header 81 (129) -> error=1, cpu_hold=1, no wr_en, in_ready=0 afterward.
REQ-041 Bench SHALL cover: header 80 with 512 bytes and random in_valid gaps -> exactly 128 writes to addresses 0..127 in order, with data matching the stream; done=1.
REQ-042 Bench SHALL cover: rst asserted after 6 data bytes of a 3-word load -> only word 0 written; state IDLE, cpu_hold=1, words_loaded=0.
REQ-043 Bench SHALL cover: start asserted during LOAD -> no effect and load completes normally; start in DONE -> done=0, cpu_hold=1, new load begins.
REQ-044 Bench SHALL cover: start and in_valid both high in IDLE with in_data=01 -> byte not consumed; it is taken in LEN the next cycle as N=1.
